// File: rtl/sccb_config_sequencer.sv
// SCCB configuration sequencer: walks a register table ROM and issues one SCCB write per
// entry, with delay entries, inter-write gaps, NACK retries, a response timeout and sticky
// completion / failure status.
module sccb_config_sequencer #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned DELAY_CYCLES   = 1_000_000,
    parameter int unsigned GAP_CYCLES     = 2_000,
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_go,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic              o_start,
    output logic [7:0]        o_sccb_addr,
    output logic [7:0]        o_sccb_data,
    input  logic              i_done,
    input  logic              i_ack_error,
    output logic              o_busy,
    output logic              o_cfg_done,
    output logic              o_cfg_error,
    output logic [ADDR_W-1:0] o_err_index
);

    // One shared down-counter serves the delay, gap and timeout intervals.
    localparam int unsigned MAX_DG  = (DELAY_CYCLES > GAP_CYCLES) ? DELAY_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_DG > TIMEOUT_CYCLES) ? MAX_DG : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 2);
    localparam int unsigned RTY_W   = $clog2(MAX_RETRY + 2);

    // Counter runs from N-1 down to 0, so a state loaded with N lasts exactly N cycles.
    localparam logic [CNT_W-1:0] LOAD_DELAY   =
        (DELAY_CYCLES == 0) ? '0 : CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_GAP     =
        (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_TIMEOUT =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0]  RETRY_MAX   = RTY_W'(MAX_RETRY);
    localparam logic [ADDR_W-1:0] LAST_IDX    = '1;

    typedef enum logic [3:0] {
        StIdle, StFetch, StDecode, StIssue, StWait, StGap, StDelay, StDone, StFail
    } state_e;

    state_e            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [RTY_W-1:0]  r_retry;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_start;
    logic [7:0]        r_sccb_addr;
    logic [7:0]        r_sccb_data;
    logic              r_busy;
    logic              r_cfg_done;
    logic              r_cfg_error;
    logic [ADDR_W-1:0] r_err_index;

    logic [ADDR_W-1:0] w_idx_inc;
    logic              w_end_entry;
    logic              w_delay_entry;
    logic              w_cnt_zero;

    // The last index doubles as an implicit end marker, so the index never needs to wrap.
    assign w_idx_inc     = (r_idx == LAST_IDX) ? r_idx : r_idx + ADDR_W'(1);
    assign w_end_entry   = (i_rom_data == 16'hFFFF) || (r_idx == LAST_IDX);
    assign w_delay_entry = (i_rom_data == 16'hFFF0);
    assign w_cnt_zero    = (r_cnt == '0);

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_retry     <= '0;
            r_cnt       <= '0;
            r_start     <= 1'b0;
            r_sccb_addr <= '0;
            r_sccb_data <= '0;
            r_busy      <= 1'b0;
            r_cfg_done  <= 1'b0;
            r_cfg_error <= 1'b0;
            r_err_index <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_go) begin
                        r_cfg_done  <= 1'b0;
                        r_cfg_error <= 1'b0;
                        r_err_index <= '0;
                        r_idx       <= '0;
                        r_retry     <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= StFetch;
                    end
                end
                // o_rom_addr already shows r_idx; this cycle covers the ROM latency.
                StFetch: r_state <= StDecode;
                StDecode: begin
                    if (w_end_entry) begin
                        r_cfg_done <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= StDone;
                    end else if (w_delay_entry) begin
                        r_cnt   <= LOAD_DELAY;
                        r_state <= StDelay;
                    end else begin
                        r_sccb_addr <= i_rom_data[15:8];
                        r_sccb_data <= i_rom_data[7:0];
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
                    r_start <= 1'b1;
                    r_cnt   <= LOAD_TIMEOUT;
                    r_state <= StWait;
                end
                StWait: begin
                    // ack_error is checked first so it wins over a simultaneous done.
                    if (i_ack_error) begin
                        r_start <= 1'b0;
                        if (r_retry < RETRY_MAX) begin
                            r_retry <= r_retry + RTY_W'(1);
                            r_cnt   <= LOAD_GAP;
                            r_state <= StGap;
                        end else begin
                            r_cfg_error <= 1'b1;
                            r_err_index <= r_idx;
                            r_busy      <= 1'b0;
                            r_state     <= StFail;
                        end
                    end else if (i_done) begin
                        r_start <= 1'b0;
                        r_retry <= '0;
                        r_idx   <= w_idx_inc;
                        r_cnt   <= LOAD_GAP;
                        r_state <= StGap;
                    end else if (w_cnt_zero) begin
                        r_start     <= 1'b0;
                        r_cfg_error <= 1'b1;
                        r_err_index <= r_idx;
                        r_busy      <= 1'b0;
                        r_state     <= StFail;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                StGap: begin
                    // A nonzero retry count means the same entry is re-issued.
                    if (w_cnt_zero) begin
                        r_state <= (r_retry == '0) ? StFetch : StIssue;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                StDelay: begin
                    if (w_cnt_zero) begin
                        r_idx   <= w_idx_inc;
                        r_state <= StFetch;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                StDone:  r_state <= StIdle;
                StFail:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_rom_addr  = r_idx;
    assign o_start     = r_start;
    assign o_sccb_addr = r_sccb_addr;
    assign o_sccb_data = r_sccb_data;
    assign o_busy      = r_busy;
    assign o_cfg_done  = r_cfg_done;
    assign o_cfg_error = r_cfg_error;
    assign o_err_index = r_err_index;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Bench for sccb_config_sequencer: table-driven walks against a modelled SCCB master and
// registered ROM, plus directed sequences for latency, timing, timeout and reset corners.
module tb_sccb_config_sequencer;

    logic        clk;
    logic        reset;
    logic        i_go;
    logic [2:0]  o_rom_addr;
    logic [15:0] i_rom_data;
    logic        o_start;
    logic [7:0]  o_sccb_addr;
    logic [7:0]  o_sccb_data;
    logic        i_done;
    logic        i_ack_error;
    logic        o_busy;
    logic        o_cfg_done;
    logic        o_cfg_error;
    logic [2:0]  o_err_index;

    sccb_config_sequencer #(
        .ADDR_W        (3),
        .MAX_RETRY     (2),
        .DELAY_CYCLES  (20),
        .GAP_CYCLES    (5),
        .TIMEOUT_CYCLES(200)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_go       (i_go),
        .o_rom_addr (o_rom_addr),
        .i_rom_data (i_rom_data),
        .o_start    (o_start),
        .o_sccb_addr(o_sccb_addr),
        .o_sccb_data(o_sccb_data),
        .i_done     (i_done),
        .i_ack_error(i_ack_error),
        .o_busy     (o_busy),
        .o_cfg_done (o_cfg_done),
        .o_cfg_error(o_cfg_error),
        .o_err_index(o_err_index)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered table ROM: data valid one clock after the address.
    logic [15:0] rom [8];
    always @(posedge clk) i_rom_data <= rom[o_rom_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // SCCB master model: answers each request 3 cycles after o_start is seen, NACKing
    // writes to m_nack_addr while m_nack_left > 0; silent mode never answers.
    logic [7:0] m_nack_addr = 8'h00;
    int         m_nack_left = 0;
    logic       m_silent    = 1'b0;
    int         n_w = 0;
    logic [7:0] w_addr [16];
    logic [7:0] w_data [16];
    int         w_cyc  [16];
    int         d_cyc  [16];

    initial begin : master
        int         k;
        logic [7:0] a;
        i_done      = 1'b0;
        i_ack_error = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (o_start === 1'b1 && !m_silent) begin
                k = n_w;
                a = o_sccb_addr;
                if (k < 16) begin
                    w_addr[k] = o_sccb_addr;
                    w_data[k] = o_sccb_data;
                    w_cyc[k]  = cyc;
                end
                n_w = n_w + 1;
                repeat (3) @(posedge clk);
                #1;
                if (k < 16) d_cyc[k] = cyc;
                if (a == m_nack_addr && m_nack_left > 0) begin
                    m_nack_left = m_nack_left - 1;
                    i_ack_error = 1'b1;
                end else begin
                    i_done = 1'b1;
                end
                @(posedge clk);
                #1;
                i_done      = 1'b0;
                i_ack_error = 1'b0;
            end
        end
    end

    typedef struct packed {
        logic [7:0][15:0] tbl;
        logic [7:0]       nack_addr;
        logic [7:0]       nack_cnt;
        logic             silent;
        logic             exp_done;
        logic             exp_err;
        logic [2:0]       exp_eidx;
        logic [4:0]       exp_nw;
        logic [7:0]       exp_la;
        logic [7:0]       exp_ld;
    } vec_t;

    vec_t vecs [8];

    task automatic set_vec(input int i, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3,
                           input logic [7:0] na, input logic [7:0] nc, input logic sil,
                           input logic ed, input logic ee, input logic [2:0] ei,
                           input logic [4:0] nw, input logic [7:0] la, input logic [7:0] ld);
        vec_t v;
        v           = '0;
        v.tbl       = '1;
        v.tbl[0]    = e0;
        v.tbl[1]    = e1;
        v.tbl[2]    = e2;
        v.tbl[3]    = e3;
        v.nack_addr = na;
        v.nack_cnt  = nc;
        v.silent    = sil;
        v.exp_done  = ed;
        v.exp_err   = ee;
        v.exp_eidx  = ei;
        v.exp_nw    = nw;
        v.exp_la    = la;
        v.exp_ld    = ld;
        vecs[i]     = v;
    endtask

    task automatic load_vec(input int i);
        for (int j = 0; j < 8; j++) rom[j] = vecs[i].tbl[j];
        m_nack_addr = vecs[i].nack_addr;
        m_nack_left = int'(vecs[i].nack_cnt);
        m_silent    = vecs[i].silent;
        n_w         = 0;
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while (o_busy && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk({name, "_busy_bound"}, o_busy, 1'b0);
    endtask

    task automatic wait_start(input string name);
        int c;
        c = 0;
        while (o_start !== 1'b1 && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk({name, "_start_seen"}, o_start, 1'b1);
    endtask

    task automatic run_walk(input int i);
        load_vec(i);
        @(posedge clk);
        #1;
        i_go = 1'b1;
        @(posedge clk);
        #1;
        i_go = 1'b0;
        chk($sformatf("v%0d_done_cleared", i), o_cfg_done, 1'b0);
        chk($sformatf("v%0d_err_cleared", i), o_cfg_error, 1'b0);
        wait_idle($sformatf("v%0d", i));
    endtask

    initial begin : main
        int last;
        int lowc;
        int c;
        reset = 1'b1;
        i_go  = 1'b0;
        for (int j = 0; j < 8; j++) rom[j] = 16'hFFFF;

        //        idx  e0        e1        e2        e3        nack   cnt  sil done err ei nw la     ld
        set_vec(0, 16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF, 8'h00, 0,   0,  1,   0,  0, 2, 8'h11, 8'h00);
        set_vec(1, 16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF, 8'h11, 2,   0,  1,   0,  0, 4, 8'h11, 8'h00);
        set_vec(2, 16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF, 8'h11, 100, 0,  0,   1,  1, 4, 8'h11, 8'h00);
        set_vec(3, 16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF, 8'h00, 0,   1,  0,   1,  0, 0, 8'h00, 8'h00);
        set_vec(4, 16'h1280, 16'hFFF0, 16'h1100, 16'hFFFF, 8'h00, 0,   0,  1,   0,  0, 2, 8'h11, 8'h00);
        set_vec(5, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'h00, 0,   0,  1,   0,  0, 7, 8'h07, 8'hA6);
        set_vec(6, 16'hFFFF, 16'h1280, 16'hFFFF, 16'hFFFF, 8'h00, 0,   0,  1,   0,  0, 0, 8'h00, 8'h00);
        set_vec(7, 16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF, 8'h12, 100, 0,  0,   1,  0, 3, 8'h12, 8'h80);
        // No end marker: index 7 is the implicit end, so entries 0..6 are written.
        for (int j = 0; j < 8; j++) vecs[5].tbl[j] = {8'(j + 1), 8'(8'hA0 + j)};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_start", o_start, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_cfg_done, 1'b0);
        chk("rst_error", o_cfg_error, 1'b0);
        chk("rst_err_index", o_err_index, 3'd0);
        chk("rst_rom_addr", o_rom_addr, 3'd0);
        chk("rst_sccb_addr", o_sccb_addr, 8'h00);
        chk("rst_sccb_data", o_sccb_data, 8'h00);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_walk(i);
            chk($sformatf("v%0d_cfg_done", i), o_cfg_done, vecs[i].exp_done);
            chk($sformatf("v%0d_cfg_error", i), o_cfg_error, vecs[i].exp_err);
            if (vecs[i].exp_err) chk($sformatf("v%0d_err_index", i), o_err_index, vecs[i].exp_eidx);
            chk($sformatf("v%0d_writes", i), n_w, vecs[i].exp_nw);
            chk($sformatf("v%0d_start_low", i), o_start, 1'b0);
            if (vecs[i].exp_nw != 0) begin
                last = (n_w > 0 && n_w <= 16) ? n_w - 1 : 0;
                chk($sformatf("v%0d_last_addr", i), w_addr[last], vecs[i].exp_la);
                chk($sformatf("v%0d_last_data", i), w_data[last], vecs[i].exp_ld);
            end
        end

        // Latency from i_go to o_start, and i_go ignored while busy.
        load_vec(0);
        @(posedge clk);
        #1;
        i_go = 1'b1;
        @(posedge clk);
        #1;
        i_go = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("lat_start_not_yet", o_start, 1'b0);
        @(posedge clk);
        #1;
        chk("lat_start_4clk", o_start, 1'b1);
        chk("lat_sccb_addr", o_sccb_addr, 8'h12);
        chk("lat_sccb_data", o_sccb_data, 8'h80);
        i_go = 1'b1;
        @(posedge clk);
        #1;
        i_go = 1'b0;
        wait_idle("busy_go");
        chk("busy_go_writes", n_w, 2);
        chk("busy_go_first_addr", w_addr[0], 8'h12);
        chk("busy_go_second_addr", w_addr[1], 8'h11);
        chk("busy_go_done", o_cfg_done, 1'b1);
        // i_go in the DONE cycle must be dropped.
        i_go = 1'b1;
        @(posedge clk);
        #1;
        i_go = 1'b0;
        chk("done_cycle_go_busy", o_busy, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("done_cycle_go_busy_later", o_busy, 1'b0);
        chk("done_cycle_go_done_kept", o_cfg_done, 1'b1);

        // Delay entry spacing.
        run_walk(4);
        lowc = (n_w >= 2) ? w_cyc[1] - d_cyc[0] - 1 : 0;
        chk("t2_delay_spacing", lowc >= 20, 1'b1);

        // Retry spacing and retried register.
        run_walk(1);
        for (int k = 1; k < 3; k++) begin
            lowc = (n_w >= 4) ? w_cyc[k + 1] - d_cyc[k] - 1 : 0;
            chk($sformatf("t3_gap_%0d", k), lowc >= 5, 1'b1);
            chk($sformatf("t3_retry_addr_%0d", k), w_addr[k + 1], 8'h11);
        end

        // Timeout window when the master stays silent.
        load_vec(3);
        @(posedge clk);
        #1;
        i_go = 1'b1;
        @(posedge clk);
        #1;
        i_go = 1'b0;
        wait_start("t5");
        c = 0;
        while (!o_cfg_error && c <= 210) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("t5_timeout_window", (c >= 190) && (c <= 200), 1'b1);
        chk("t5_err_index", o_err_index, 3'd0);
        chk("t5_start_dropped", o_start, 1'b0);

        // Reset while waiting on the master, then a fresh walk from index 0.
        load_vec(0);
        @(posedge clk);
        #1;
        i_go = 1'b1;
        @(posedge clk);
        #1;
        i_go = 1'b0;
        wait_start("t6");
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_start", o_start, 1'b0);
        chk("t6_busy", o_busy, 1'b0);
        chk("t6_done", o_cfg_done, 1'b0);
        chk("t6_error", o_cfg_error, 1'b0);
        chk("t6_rom_addr", o_rom_addr, 3'd0);
        chk("t6_sccb_addr", o_sccb_addr, 8'h00);
        chk("t6_sccb_data", o_sccb_data, 8'h00);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        run_walk(0);
        chk("t6_rewalk_writes", n_w, 2);
        chk("t6_rewalk_first_addr", w_addr[0], 8'h12);
        chk("t6_rewalk_first_data", w_data[0], 8'h80);
        chk("t6_rewalk_done", o_cfg_done, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
